smc_soc_cpu_oci_dct_ctrl: RTL and testbench
===========================================

SMC_SOC_CPU_OCI_DCT_CTRL -- requirements
Module: smc_soc_CPU_oci_dct_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous active-high reset.
REQ-004 enable  input  1  capture enable; 0 forces the block to IDLE.
REQ-005 frag_valid  input  1  data-trace fragment present this cycle; not stallable.
REQ-006 frag_data  input  2  fragment payload.
REQ-007 flush  input  1  single-cycle request to emit a partial word.
REQ-008 word_ready  input  1  downstream trace sink accepts word_data.
REQ-009 dct_buffer  output  30  packing buffer; newest fragment in bits [1:0].
REQ-010 dct_count  output  4  fragments held in dct_buffer, 0..15.
REQ-011 word_valid  output  1  word_data/word_len valid.
REQ-012 word_data  output  30  emitted word.
REQ-013 word_len  output  4  fragment count of the emitted word, 1..15.
REQ-014 overflow  output  1  sticky: at least one fragment dropped since reset or enable rise.
REQ-015 ovf_count  output  16  dropped-fragment count (present only per REQ-032).

Function
REQ-016 States: IDLE, FILL, FULL; IDLE->FILL when enable=1; any state->IDLE when enable=0.
REQ-017 In IDLE, dct_buffer, dct_count and the output register SHALL clear; fragments ignored and not counted as drops.
REQ-018 In FILL, an accepted fragment SHALL set dct_buffer <= {dct_buffer[27:0], frag_data} and increment dct_count, one-cycle latency.
REQ-019 When an accepted fragment makes the count 15 and the output register is empty (or emptied this cycle by word_valid&word_ready), the full 30-bit word SHALL load the output register the same edge with word_len=15, and dct_buffer/dct_count SHALL clear.
REQ-020 If the count reaches 15 and the output register stays occupied, the block SHALL enter FULL, holding dct_buffer and dct_count=15.
REQ-021 In FULL, every frag_valid SHALL be dropped; on output register free, the held word loads and the state returns to FILL with count 0.
REQ-022 A fragment arriving the same cycle FULL exits SHALL be accepted into the cleared buffer (count 1).
REQ-023 word_valid SHALL remain asserted with stable word_data/word_len until word_valid&word_ready; the register frees on that edge.
REQ-024 flush in FILL with dct_count>0 and output register free SHALL emit dct_buffer with word_len=dct_count, upper unused bits zero, and clear the buffer.
REQ-025 flush with a simultaneous fragment SHALL append the fragment first and emit it in the same word.
REQ-026 flush with dct_count=0 (after REQ-025) SHALL be ignored; flush with output register occupied SHALL be held pending until it frees, fragments continuing to pack meanwhile.
REQ-027 A drop SHALL set overflow, which clears only on reset or IDLE->FILL transition.
REQ-028 Disabling mid-word SHALL discard the partial word and any unaccepted output word without emission.

Reset
REQ-029 On reset: state IDLE, dct_buffer=0, dct_count=0, word_valid=0, word_data=0, word_len=0, overflow=0, ovf_count=0, pending flush cleared.
REQ-030 Reset SHALL take priority over all other inputs in the same cycle.

Configuration
REQ-031 Macro SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN SHALL control the drop counter.
REQ-032 Defined: ovf_count increments per dropped fragment, saturates at 16'hFFFF, clears as overflow does; undefined: ovf_count port is absent and no counter logic is built, overflow unchanged.

Verification
REQ-033 enable=1, word_ready=1, 15 fragments 2'b01 back-to-back -> word_valid one cycle after the 15th, word_data=30'h15555555, word_len=15, dct_count=0.
REQ-034 5 fragments 2'b11 then flush -> word_data=30'h000003FF, word_len=5.
REQ-035 word_ready=0, 31 fragments -> first word held, second fills to FULL, 31st dropped, overflow=1, ovf_count=1 (macro defined).
REQ-036 3 fragments then flush coincident with 4th fragment 2'b10 -> word_len=4, word_data[1:0]=2'b10.
REQ-037 7 fragments then enable=0 -> next cycle dct_count=0, word_valid=0, no word emitted; re-enable clears overflow.
REQ-038 reset asserted mid-FILL with word_valid=1 -> next cycle all outputs zero, state IDLE.

Source files
------------

// File: rtl/smc_soc_cpu_oci_dct_ctrl.sv
// Data-trace fragment packer: shifts 2-bit fragments into a 30-bit word and hands words to the trace sink.
// Defining SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN adds the saturating ovf_count drop counter port.
module smc_soc_cpu_oci_dct_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        frag_valid,
  input  logic [1:0]  frag_data,
  input  logic        flush,
  input  logic        word_ready,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        word_valid,
  output logic [29:0] word_data,
  output logic [3:0]  word_len,
  output logic        overflow
`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
  ,
  output logic [15:0] ovf_count
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t      state_r, state_nx_s;
  logic [29:0] buf_r, buf_nx_s;
  logic [3:0]  cnt_r, cnt_nx_s;
  logic        wv_r, wv_nx_s;
  logic [29:0] wd_r, wd_nx_s;
  logic [3:0]  wl_r, wl_nx_s;
  logic        ovf_r, ovf_nx_s;
  logic        pend_r, pend_nx_s;

  logic        out_free_s;
  logic        flush_req_s;
  logic        drop_s;
  logic        ovf_clr_s;
  logic [29:0] fill_buf_s;
  logic [3:0]  fill_cnt_s;

  // Buffer contents after this cycle's fragment, and the combined live/pending flush request
  always_comb begin
    out_free_s  = !wv_r || word_ready;
    flush_req_s = flush || pend_r;
    if (frag_valid) begin
      fill_buf_s = {buf_r[27:0], frag_data};
      fill_cnt_s = cnt_r + 4'd1;
    end else begin
      fill_buf_s = buf_r;
      fill_cnt_s = cnt_r;
    end
  end

  // Next-state, packing buffer and output word register decisions
  always_comb begin
    state_nx_s = state_r;
    buf_nx_s   = buf_r;
    cnt_nx_s   = cnt_r;
    wv_nx_s    = wv_r && !word_ready;
    wd_nx_s    = wd_r;
    wl_nx_s    = wl_r;
    pend_nx_s  = pend_r;
    drop_s     = 1'b0;
    ovf_clr_s  = 1'b0;
    if (!enable) begin
      // Disabling discards both the partial word and any unaccepted output word
      state_nx_s = ST_IDLE;
      buf_nx_s   = 30'd0;
      cnt_nx_s   = 4'd0;
      wv_nx_s    = 1'b0;
      wd_nx_s    = 30'd0;
      wl_nx_s    = 4'd0;
      pend_nx_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nx_s = ST_FILL;
          buf_nx_s   = 30'd0;
          cnt_nx_s   = 4'd0;
          wv_nx_s    = 1'b0;
          wd_nx_s    = 30'd0;
          wl_nx_s    = 4'd0;
          pend_nx_s  = 1'b0;
          ovf_clr_s  = 1'b1;
        end
        ST_FILL: begin
          buf_nx_s = fill_buf_s;
          cnt_nx_s = fill_cnt_s;
          if (fill_cnt_s == 4'd15) begin
            pend_nx_s = 1'b0;
            if (out_free_s) begin
              wv_nx_s  = 1'b1;
              wd_nx_s  = fill_buf_s;
              wl_nx_s  = 4'd15;
              buf_nx_s = 30'd0;
              cnt_nx_s = 4'd0;
            end else begin
              state_nx_s = ST_FULL;
            end
          end else if (flush_req_s && (fill_cnt_s != 4'd0)) begin
            // Upper bits are already zero: the buffer is cleared on every emission
            if (out_free_s) begin
              wv_nx_s   = 1'b1;
              wd_nx_s   = fill_buf_s;
              wl_nx_s   = fill_cnt_s;
              buf_nx_s  = 30'd0;
              cnt_nx_s  = 4'd0;
              pend_nx_s = 1'b0;
            end else begin
              pend_nx_s = 1'b1;
            end
          end else begin
            pend_nx_s = 1'b0;
          end
        end
        ST_FULL: begin
          pend_nx_s = 1'b0;
          if (out_free_s) begin
            state_nx_s = ST_FILL;
            wv_nx_s    = 1'b1;
            wd_nx_s    = buf_r;
            wl_nx_s    = 4'd15;
            if (frag_valid) begin
              buf_nx_s  = {28'd0, frag_data};
              cnt_nx_s  = 4'd1;
              pend_nx_s = flush;
            end else begin
              buf_nx_s = 30'd0;
              cnt_nx_s = 4'd0;
            end
          end else begin
            drop_s = frag_valid;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
          buf_nx_s   = 30'd0;
          cnt_nx_s   = 4'd0;
          wv_nx_s    = 1'b0;
          wd_nx_s    = 30'd0;
          wl_nx_s    = 4'd0;
          pend_nx_s  = 1'b0;
        end
      endcase
    end
    ovf_nx_s = ovf_clr_s ? 1'b0 : (ovf_r || drop_s);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      buf_r   <= 30'd0;
      cnt_r   <= 4'd0;
      wv_r    <= 1'b0;
      wd_r    <= 30'd0;
      wl_r    <= 4'd0;
      ovf_r   <= 1'b0;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      buf_r   <= buf_nx_s;
      cnt_r   <= cnt_nx_s;
      wv_r    <= wv_nx_s;
      wd_r    <= wd_nx_s;
      wl_r    <= wl_nx_s;
      ovf_r   <= ovf_nx_s;
      pend_r  <= pend_nx_s;
    end
  end

`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
  logic [15:0] ovf_cnt_r;

  // Saturating dropped-fragment counter, cleared alongside overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_cnt_r <= 16'd0;
    end else if (ovf_clr_s) begin
      ovf_cnt_r <= 16'd0;
    end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end else begin
      ovf_cnt_r <= ovf_cnt_r;
    end
  end

  assign ovf_count = ovf_cnt_r;
`endif

  assign dct_buffer = buf_r;
  assign dct_count  = cnt_r;
  assign word_valid = wv_r;
  assign word_data  = wd_r;
  assign word_len   = wl_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_smc_soc_cpu_oci_dct_ctrl.sv
// Bench for smc_soc_cpu_oci_dct_ctrl: a vector table, directed corner sequences and random traffic,
// all cross-checked every cycle against a queue-based fragment model.
module tb_smc_soc_cpu_oci_dct_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        frag_valid = 1'b0;
  logic [1:0]  frag_data = 2'd0;
  logic        flush = 1'b0;
  logic        word_ready = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        word_valid;
  logic [29:0] word_data;
  logic [3:0]  word_len;
  logic        overflow;
`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
  logic [15:0] ovf_count;
`endif

  always #5 clk = ~clk;

  smc_soc_cpu_oci_dct_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .frag_valid (frag_valid),
    .frag_data  (frag_data),
    .flush      (flush),
    .word_ready (word_ready),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_len   (word_len),
    .overflow   (overflow)
`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
    ,
    .ovf_count  (ovf_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Model: the buffer is a list of fragments; a word is their base-4 concatenation
  bit          m_act;
  int          m_q[$];
  bit          m_wv;
  logic [29:0] m_wd;
  logic [3:0]  m_wl;
  bit          m_ovf;
  bit          m_pend;
  int          m_oc;

  function automatic logic [29:0] pack_q();
    logic [29:0] v = 30'd0;
    for (int i = 0; i < m_q.size(); i++) v = {v[27:0], 2'(m_q[i])};
    return v;
  endfunction

  task automatic emit();
    m_wv = 1'b1;
    m_wd = pack_q();
    m_wl = 4'(m_q.size());
    m_q.delete();
  endtask

  task automatic model_step(input bit r, e, v, input logic [1:0] d, input bit f, w);
    if (r) begin
      m_act = 0; m_q.delete(); m_wv = 0; m_wd = '0; m_wl = '0;
      m_ovf = 0; m_pend = 0; m_oc = 0;
    end else if (!e) begin
      m_act = 0; m_q.delete(); m_wv = 0; m_wd = '0; m_wl = '0; m_pend = 0;
    end else if (!m_act) begin
      m_act = 1; m_q.delete(); m_wv = 0; m_wd = '0; m_wl = '0;
      m_pend = 0; m_ovf = 0; m_oc = 0;
    end else begin
      if (m_wv && w) m_wv = 0;
      if (m_q.size() == 15) begin
        m_pend = 0;
        if (!m_wv) begin
          emit();
          if (v) begin m_q.push_back(int'(d)); m_pend = f; end
        end else if (v) begin
          m_ovf = 1;
          if (m_oc < 65535) m_oc++;
        end
      end else begin
        if (v) m_q.push_back(int'(d));
        if (m_q.size() == 15) begin
          m_pend = 0;
          if (!m_wv) emit();
        end else if ((f || m_pend) && m_q.size() > 0) begin
          if (!m_wv) begin emit(); m_pend = 0; end
          else m_pend = 1;
        end else begin
          m_pend = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit r, e, v, input logic [1:0] d, input bit f, w);
    reset = r; enable = e; frag_valid = v; frag_data = d; flush = f; word_ready = w;
    model_step(r, e, v, d, f, w);
    @(posedge clk);
    #1;
    chk("m_word_valid", word_valid, m_wv);
    chk("m_word_data", word_data, m_wd);
    chk("m_word_len", word_len, m_wl);
    chk("m_dct_count", dct_count, m_q.size());
    chk("m_dct_buffer", dct_buffer, pack_q());
    chk("m_overflow", overflow, m_ovf);
`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
    chk("m_ovf_count", ovf_count, m_oc);
`endif
  endtask

  typedef struct {
    bit r, e, v; logic [1:0] d; bit f, w;
    bit xv; logic [29:0] xd; logic [3:0] xl; logic [3:0] xc; logic [29:0] xb; bit xo;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd0, 30'h0,   1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd0, 30'h0,   1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd1, 30'h3,   1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd2, 30'hF,   1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd3, 30'h3F,  1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd4, 30'hFF,  1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd5, 30'h3FF, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 30'h3FF, 4'd5, 4'd0, 30'h0,  1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd1, 30'h1,   1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd2, 30'h6,   1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd3, 30'h1B,  1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 30'h6E, 4'd4, 4'd0, 30'h0,   1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 30'h6E, 4'd4, 4'd0, 30'h0,   1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 30'h6E, 4'd4, 4'd1, 30'h1,   1'b0};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 30'h7,  4'd2, 4'd0, 30'h0,   1'b0};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 4'd0, 30'h0,   1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 30'h0,  4'd0, 4'd0, 30'h0,   1'b0};

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].w);
      chk($sformatf("tbl%0d_valid", i), word_valid, tbl[i].xv);
      chk($sformatf("tbl%0d_count", i), dct_count, tbl[i].xc);
      chk($sformatf("tbl%0d_buffer", i), dct_buffer, tbl[i].xb);
      chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].xo);
      if (tbl[i].xv) begin
        chk($sformatf("tbl%0d_data", i), word_data, tbl[i].xd);
        chk($sformatf("tbl%0d_len", i), word_len, tbl[i].xl);
      end
    end

    // Fifteen back-to-back fragments produce a full word the next cycle
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    chk("full_valid", word_valid, 1'b1);
    chk("full_data", word_data, 30'h15555555);
    chk("full_len", word_len, 4'd15);
    chk("full_count", dct_count, 4'd0);

    // Blocked sink: second word parks in FULL, later fragments are dropped
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("blk_first_data", word_data, 30'h2AAAAAAA);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
      if (i == 14) chk("blk_nodrop_yet", overflow, 1'b0);
    end
    chk("blk_count15", dct_count, 4'd15);
    chk("blk_buffer", dct_buffer, 30'h3FFFFFFF);
    chk("blk_overflow", overflow, 1'b1);
`ifdef SMC_SOC_CPU_OCI_DCT_OVF_CNT_EN
    chk("blk_ovf_count", ovf_count, 16'd1);
`endif
    // Fragment on the FULL exit cycle lands in the cleared buffer
    step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    chk("exit_data", word_data, 30'h3FFFFFFF);
    chk("exit_count", dct_count, 4'd1);
    chk("exit_buffer", dct_buffer, 30'h1);
    chk("exit_overflow", overflow, 1'b1);

    // Disable mid-word discards it; re-enable clears overflow and ignores that cycle's fragment
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b1);
    chk("dis_pre_count", dct_count, 4'd7);
    step(1'b0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0);
    chk("dis_count", dct_count, 4'd0);
    chk("dis_valid", word_valid, 1'b0);
    chk("dis_ovf_sticky", overflow, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    chk("reen_overflow", overflow, 1'b0);
    chk("reen_count", dct_count, 4'd0);

    // Reset mid-FILL with a word waiting
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("rst_pre_valid", word_valid, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1);
    chk("rst_valid", word_valid, 1'b0);
    chk("rst_data", word_data, 30'h0);
    chk("rst_len", word_len, 4'd0);
    chk("rst_count", dct_count, 4'd0);
    chk("rst_buffer", dct_buffer, 30'h0);
    step(1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 1'b1);
    chk("rst_idle_count", dct_count, 4'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 39) != 0),
           ($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
